// File: rtl/excess3_bcd_pkg.sv
// Shared types and constants for the multi-digit Excess-3 to BCD converter.
package excess3_bcd_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] E3_OFFSET = 4'd3;
  localparam logic [DIGIT_W-1:0] E3_MIN    = 4'b0011;
  localparam logic [DIGIT_W-1:0] E3_MAX    = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/e3_digit_conv.sv
// Combinational single-digit Excess-3 to BCD converter; invalid codes map to 0.
module e3_digit_conv
  import excess3_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] code,
  output logic [DIGIT_W-1:0] bcd,
  output logic               invalid
);

  always_comb begin
    invalid = (code < E3_MIN) || (code > E3_MAX);
    bcd     = invalid ? '0 : (code - E3_OFFSET);
  end

endmodule

// File: rtl/excess3_bcd_seq_ctrl.sv
// Sequential Excess-3 to BCD word converter, one digit per cycle, LSD first.
// Define E3_ERR_MASK_EN to add the per-digit out_err_mask output.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never drops before that transfer and ready never looks at valid.
module excess3_bcd_seq_ctrl
  import excess3_bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIGIT_W*DIGITS-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DIGIT_W*DIGITS-1:0] out_data,
  output logic                    out_err,
`ifdef E3_ERR_MASK_EN
  output logic [DIGITS-1:0]       out_err_mask,
`endif
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  localparam int W     = DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [W-1:0]       shreg;
  logic [W-1:0]       result;
  logic [DIGITS-1:0]  err_mask;
  logic [DIGIT_W-1:0] dig_bcd;
  logic               dig_inv;
  logic               accept;
  logic               last;

  // The shift register always presents the current digit in its low nibble.
  e3_digit_conv u_conv (
    .code    (shreg[DIGIT_W-1:0]),
    .bcd     (dig_bcd),
    .invalid (dig_inv)
  );

  assign last   = (idx == IDX_W'(DIGITS - 1));
  assign accept = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CONV;
      end
      CONV: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) begin
          in_ready  = 1'b1;
          state_nxt = in_valid ? CONV : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      shreg    <= '0;
      result   <= '0;
      err_mask <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        shreg    <= in_data;
        result   <= '0;
        err_mask <= '0;
        idx      <= '0;
      end else if (state == CONV) begin
        shreg <= shreg >> DIGIT_W;
        for (int k = 0; k < DIGITS; k++) begin
          if (idx == IDX_W'(k)) begin
            result[k*DIGIT_W +: DIGIT_W] <= dig_bcd;
            err_mask[k]                  <= dig_inv;
          end
        end
        idx <= last ? '0 : idx + 1'b1;
      end
    end
  end

  assign out_valid = (state == DONE);
  assign busy      = (state == CONV);
  assign out_data  = result;
  assign out_err   = |err_mask;
  assign dbg_state = state;
`ifdef E3_ERR_MASK_EN
  assign out_err_mask = err_mask;
`endif

endmodule

// File: tb/tb_excess3_bcd_seq_ctrl.sv
// Scoreboard bench for excess3_bcd_seq_ctrl at DIGITS = 4, 1 and 8.
// Honours E3_ERR_MASK_EN when defined.
module tb_excess3_bcd_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dut a: DIGITS=4, dut b: DIGITS=1, dut c: DIGITS=8
  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_err_a, busy_a;
  logic [15:0] in_data_a, out_data_a;
  logic [1:0]  dbg_state_a;
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_err_b, busy_b;
  logic [3:0]  in_data_b, out_data_b;
  logic [1:0]  dbg_state_b;
  logic        in_valid_c, in_ready_c, out_valid_c, out_ready_c, out_err_c, busy_c;
  logic [31:0] in_data_c, out_data_c;
  logic [1:0]  dbg_state_c;
`ifdef E3_ERR_MASK_EN
  logic [3:0]  out_err_mask_a;
  logic [0:0]  out_err_mask_b;
  logic [7:0]  out_err_mask_c;
`endif

  excess3_bcd_seq_ctrl #(.DIGITS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_data(out_data_a), .out_err(out_err_a),
`ifdef E3_ERR_MASK_EN
    .out_err_mask(out_err_mask_a),
`endif
    .busy(busy_a), .dbg_state(dbg_state_a)
  );

  excess3_bcd_seq_ctrl #(.DIGITS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .out_err(out_err_b),
`ifdef E3_ERR_MASK_EN
    .out_err_mask(out_err_mask_b),
`endif
    .busy(busy_b), .dbg_state(dbg_state_b)
  );

  excess3_bcd_seq_ctrl #(.DIGITS(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .in_data(in_data_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
    .out_data(out_data_c), .out_err(out_err_c),
`ifdef E3_ERR_MASK_EN
    .out_err_mask(out_err_mask_c),
`endif
    .busy(busy_c), .dbg_state(dbg_state_c)
  );

  // expected entry = {mask[7:0], err, data[31:0]}
  logic [40:0] exp_a[$], exp_b[$], exp_c[$];
  logic [40:0] ea, eb, ec;

  logic [3:0] bcd_tbl [16] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                               4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd0, 4'd0};
  logic       inv_tbl [16] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  function automatic logic [40:0] pack(logic [7:0] m, logic e, logic [31:0] d);
    return {m, e, d};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid_a && out_ready_a) begin
      if (exp_a.size() == 0) check("a_unexpected_out", 1, 0);
      else begin
        ea = exp_a.pop_front();
        check("a_data", out_data_a, ea[31:0]);
        check("a_err", out_err_a, ea[32]);
`ifdef E3_ERR_MASK_EN
        check("a_mask", out_err_mask_a, ea[40:33]);
`endif
      end
    end
    if (rst_n && out_valid_b && out_ready_b) begin
      if (exp_b.size() == 0) check("b_unexpected_out", 1, 0);
      else begin
        eb = exp_b.pop_front();
        check("b_data", out_data_b, eb[31:0]);
        check("b_err", out_err_b, eb[32]);
`ifdef E3_ERR_MASK_EN
        check("b_mask", out_err_mask_b, eb[40:33]);
`endif
      end
    end
    if (rst_n && out_valid_c && out_ready_c) begin
      if (exp_c.size() == 0) check("c_unexpected_out", 1, 0);
      else begin
        ec = exp_c.pop_front();
        check("c_data", out_data_c, ec[31:0]);
        check("c_err", out_err_c, ec[32]);
`ifdef E3_ERR_MASK_EN
        check("c_mask", out_err_mask_c, ec[40:33]);
`endif
      end
    end
  end

  // ---------------- driver helpers ----------------
  function automatic logic rdy(int sel);
    case (sel)
      0:       return in_ready_a;
      1:       return in_ready_b;
      default: return in_ready_c;
    endcase
  endfunction

  function automatic logic ovld(int sel);
    case (sel)
      0:       return out_valid_a;
      1:       return out_valid_b;
      default: return out_valid_c;
    endcase
  endfunction

  function automatic logic [1:0] st(int sel);
    case (sel)
      0:       return dbg_state_a;
      1:       return dbg_state_b;
      default: return dbg_state_c;
    endcase
  endfunction

  task automatic set_in(int sel, logic v, logic [31:0] d);
    case (sel)
      0:       begin in_valid_a = v; in_data_a = d[15:0]; end
      1:       begin in_valid_b = v; in_data_b = d[3:0];  end
      default: begin in_valid_c = v; in_data_c = d;       end
    endcase
  endtask

  // Called #1 after a rising edge; returns #1 after the acceptance edge.
  task automatic send(int sel, logic [31:0] d, logic [40:0] expv, bit push);
    int n = 0;
    set_in(sel, 1'b1, d);
    do begin
      @(negedge clk);
      n++;
    end while (!rdy(sel) && n < 50);
    check("send_in_ready", rdy(sel), 1);
    @(posedge clk);
    if (push) begin
      case (sel)
        0:       exp_a.push_back(expv);
        1:       exp_b.push_back(expv);
        default: exp_c.push_back(expv);
      endcase
    end
    #1 set_in(sel, 1'b0, d);
  endtask

  // Returns on the falling edge where out_valid is first seen high.
  task automatic wait_out(int sel);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ovld(sel) && n < 50);
    check("wait_out_valid", ovld(sel), 1);
  endtask

  task automatic wait_idle(int sel);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (st(sel) != 2'd0 && n < 100);
    check("wait_idle_state", st(sel), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat, busy_cnt, t0;
    rst_n = 1'b0;
    in_valid_a = 0; in_data_a = '0; out_ready_a = 1;
    in_valid_b = 0; in_data_b = '0; out_ready_b = 1;
    in_valid_c = 0; in_data_c = '0; out_ready_c = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid_a, 0);
    check("rst_out_data", out_data_a, 0);
    check("rst_out_err", out_err_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_state", dbg_state_a, 0);
    check("rst_in_ready", in_ready_a, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic conversion with latency and busy length
    send(0, 32'h3456, pack(8'h00, 0, 32'h0123), 1);
    lat = 1;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_a) busy_cnt++;
      if (out_valid_a) break;
      @(posedge clk);
      lat++;
    end
    check("a_latency_edges", lat, 5);
    check("a_busy_cycles", busy_cnt, 4);
    wait_idle(0);

    // invalid codes and another valid mix
    send(0, 32'h3C3F, pack(8'h01, 1, 32'h0900), 1);
    wait_idle(0);
    send(0, 32'h0D2E, pack(8'h0F, 1, 32'h0000), 1);
    wait_idle(0);
    send(0, 32'h4C75, pack(8'h00, 0, 32'h1942), 1);
    wait_idle(0);

    // back-pressure: result held, input changes ignored
    out_ready_a = 0;
    send(0, 32'h5B68, pack(8'h00, 0, 32'h2835), 1);
    wait_out(0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 in_data_a = 16'($urandom_range(0, 16'hFFFF));
      @(negedge clk);
      check("bp_out_valid", out_valid_a, 1);
      check("bp_out_data", out_data_a, 16'h2835);
      check("bp_out_err", out_err_a, 0);
      check("bp_in_ready", in_ready_a, 0);
    end
    @(posedge clk);
    #1 out_ready_a = 1;
    wait_idle(0);

    // back-to-back: second word accepted in the DONE cycle
    in_valid_a = 1;
    in_data_a = 16'h3333;
    t0 = 0;
    for (int i = 0; i < 50 && !in_ready_a; i++) @(negedge clk);
    @(negedge clk);
    check("b2b_first_ready", in_ready_a, 1);
    t0 = cyc;
    @(posedge clk);
    exp_a.push_back(pack(8'h00, 0, 32'h0000));
    #1 in_data_a = 16'hCCCC;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready_a) break;
    end
    check("b2b_accept_in_done", out_valid_a, 1);
    check("b2b_gap_edges", cyc - t0, 5);
    @(posedge clk);
    exp_a.push_back(pack(8'h00, 0, 32'h9999));
    #1 in_valid_a = 0;
    wait_idle(0);

    // reset during the second CONV cycle
    send(0, 32'h4567, pack(8'h00, 0, 32'h0000), 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid_a, 0);
    check("midrst_out_data", out_data_a, 0);
    check("midrst_out_err", out_err_a, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_state", dbg_state_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("postrst_out_valid", out_valid_a, 0);
      check("postrst_in_ready", in_ready_a, 1);
    end
    @(posedge clk);
    #1;

    // DIGITS=1: latency, then the full code sweep
    send(1, 32'hC, pack(8'h00, 0, 32'h9), 1);
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid_b) break;
      @(posedge clk);
      lat++;
    end
    check("b_latency_edges", lat, 2);
    wait_idle(1);
    for (int c = 0; c < 16; c++) begin
      send(1, 32'(c), pack({7'd0, inv_tbl[c]}, inv_tbl[c], {28'd0, bcd_tbl[c]}), 1);
      wait_idle(1);
    end

    // DIGITS=8
    send(2, 32'h3456789A, pack(8'h00, 0, 32'h01234567), 1);
    wait_idle(2);
    send(2, 32'hF3333330, pack(8'h81, 1, 32'h00000000), 1);
    wait_idle(2);

    repeat (3) @(posedge clk);
    check("a_queue_empty", exp_a.size(), 0);
    check("b_queue_empty", exp_b.size(), 0);
    check("c_queue_empty", exp_c.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/excess3_bcd_seq_ctrl.md
Name: excess3_bcd_seq_ctrl

Overview:
Multi-digit Excess-3 to BCD converter built around one shared single-digit converter. The controller accepts a packed DIGITS-wide Excess-3 word over a valid/ready handshake and converts one digit per cycle, least significant digit first. It returns the packed BCD word and an invalid-code flag over a second valid/ready handshake. It sits between an upstream Excess-3 code source and downstream BCD consumers such as display drivers.

Parameters:
DIGITS, 4, number of 4-bit digits per word; legal range 1..8.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  upstream word available.
in_ready  output  1  controller can accept a word this cycle.
in_data  input  4*DIGITS  packed Excess-3 word; digit k occupies bits [4k+3:4k].
out_valid  output  1  converted word held on out_data/out_err.
out_ready  input  1  downstream accepts the result.
out_data  output  4*DIGITS  packed BCD result; same digit layout as in_data.
out_err  output  1  at least one input digit was an invalid Excess-3 code.
busy  output  1  high while the state is CONV.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE
  - out_valid = 0, out_data = 0, out_err = 0
  - digit index = 0, busy = 0
  - Reset mid-conversion or with out_valid held discards the word, with no partial output.
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready = 1.
  - When in_valid is high, latch in_data into the shift register, clear the result and err accumulators, set idx = 0, and go to CONV.
- CONV:
  - in_ready = 0, busy = 1.
  - Each cycle, digit idx of the latched word goes through the shared converter.
  - The result is written to BCD digit slot idx, and idx increments.
  - After digit DIGITS-1 (DIGITS cycles in CONV), go to DONE with out_valid = 1.
- DONE:
  - out_valid = 1; out_data and out_err stay stable until the handshake completes.
  - If out_ready is low, hold state and outputs (back-pressure, no timeout).
  - If out_ready is high and in_valid is low, go to IDLE with out_valid = 0.
  - If out_ready is high and in_valid is high, in_ready = 1. The new word is latched and the state goes directly to CONV (back-to-back, no bubble).
- in_ready is combinational: it is 1 when state == IDLE, or when state == DONE and out_ready = 1. It never depends on in_valid.
- Latency: acceptance edge to out_valid = DIGITS+1 rising edges. Throughput is one word per DIGITS+1 cycles.
- Digit rule:
  - Valid Excess-3 codes are 0011..1100, and BCD = code - 3 (4-bit).
  - Codes 0000..0010 and 1101..1111 are invalid: the BCD digit is forced to 0000 and the sticky err accumulator is set.
- in_data changes while the state is not IDLE are ignored because the word is latched.
- out_valid never drops without out_ready = 1.
- For DIGITS = 1: one CONV cycle, then DONE.

Optional Feature:
Macro E3_ERR_MASK_EN.
- Defined: adds output port out_err_mask, width DIGITS. Bit k = 1 means input digit k was invalid. It has the same reset, update and hold rules as out_err, and out_err = OR of out_err_mask.
- Undefined: the port is absent and only the aggregate out_err exists. No other behaviour changes.

Decomposition:
- Package excess3_bcd_pkg:
  - state enum (IDLE, CONV, DONE)
  - constant E3_OFFSET = 4'd3
  - constants E3_MIN = 4'b0011 and E3_MAX = 4'b1100
  - digit width constant DIGIT_W = 4
- Sub-module e3_digit_conv: purely combinational.
  - Inputs: 4-bit code. Outputs: 4-bit BCD and a 1-bit invalid flag.
  - Implements the digit rule and is instantiated once.
- The controller holds the FSM, index counter, input shift register and result/err accumulators.

Test Plan:
1. Basic conversion: reset, then DIGITS = 4, in_data = 16'h3456, in_valid one cycle -> out_valid rises 5 edges after acceptance; out_data = 16'h0123, out_err = 0, busy high exactly 4 cycles.
2. Invalid code: in_data = 16'h3C3F -> out_data = 16'h0900, out_err = 1; with E3_ERR_MASK_EN, out_err_mask = 4'b0001. Also all 16 single-digit codes against the rule.
3. Back-pressure: out_ready held 0 for 10 cycles after out_valid -> out_valid, out_data and out_err stable, in_ready = 0 throughout; in_data changes ignored.
4. Back-to-back: in_valid constantly high with words 16'h3333 then 16'hCCCC, out_ready = 1 -> results 16'h0000 then 16'h9999, second word accepted in the DONE cycle, with no idle cycle between words.
5. Reset mid-operation: assert rst_n = 0 on the 2nd CONV cycle of 16'h4567 -> outputs zero immediately (async), state IDLE; after release, in_ready = 1 and no stale out_valid appears.
6. Edge sizes: DIGITS = 1 with in_data = 4'hC -> out_data = 4'h9 two edges after acceptance; DIGITS = 8 with 32'h3456789A -> 32'h01234567.
